// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// State encoding, operation codes and address/data widths live here.
package dmem_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;

endpackage

// File: rtl/dmem_array.sv
// 256x8 storage with a synchronous write port and an asynchronous read port.
// Contents are deliberately not reset.
module dmem_array
  import dmem_pkg::*;
(
  input  logic              clock,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clock) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: IDLE/WAIT/DONE handshake FSM in front of dmem_array.
// Define DMEM_WAIT_STATE_EN to compile in WAIT_CYCLES wait states per access.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int WAIT_CYCLES = 2
)
(
  input  logic              clock,
  input  logic              reset,
  input  logic              Rm,
  input  logic              Wm,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] RegVal,
  output logic [DATA_W-1:0] Data_out,
  output logic              ready,
  output logic              done,
  output logic              err
);

  if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_badWaitCycles
    $error("dmem_responder: WAIT_CYCLES must be in 1..15");
  end

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_op;
  logic [DATA_W-1:0] r_dataOut;
  logic              r_done;
  logic              r_err;

  logic              w_idle;
  logic              w_oneStrobe;
  logic              w_idleAccess;
  logic              w_waitAccess;
  logic              w_memWe;
  logic [ADDR_W-1:0] w_memAddr;
  logic [DATA_W-1:0] w_memWdata;
  logic [DATA_W-1:0] w_memRdata;

  assign w_idle      = (r_state == IDLE);
  assign w_oneStrobe = Rm ^ Wm;

`ifdef DMEM_WAIT_STATE_EN
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);
  logic [3:0] r_cnt;

  assign w_idleAccess = 1'b0;
  assign w_waitAccess = (r_state == WAIT) && (r_cnt == 4'd1);
`else
  assign w_idleAccess = w_idle && w_oneStrobe;
  assign w_waitAccess = 1'b0;
`endif

  // Live inputs address the array on the capture edge; latched copies afterwards.
  assign w_memAddr  = w_idle ? address : r_addr;
  assign w_memWdata = w_idle ? RegVal  : r_wdata;
  assign w_memWe    = !reset && ((w_idleAccess && Wm) ||
                                 (w_waitAccess && (r_op == OP_WR)));

  dmem_array u_array (
    .clock   (clock),
    .i_we    (w_memWe),
    .i_addr  (w_memAddr),
    .i_wdata (w_memWdata),
    .o_rdata (w_memRdata)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_op      <= OP_RD;
      r_dataOut <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
`ifdef DMEM_WAIT_STATE_EN
      r_cnt     <= 4'd0;
`endif
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (Rm && Wm) begin
            r_err <= 1'b1;
          end else if (w_oneStrobe) begin
            r_addr  <= address;
            r_wdata <= RegVal;
            r_op    <= Wm ? OP_WR : OP_RD;
`ifdef DMEM_WAIT_STATE_EN
            r_cnt   <= WAIT_LOAD;
            r_state <= WAIT;
`else
            if (Rm) begin
              r_dataOut <= w_memRdata;
            end
            r_done  <= 1'b1;
            r_state <= DONE;
`endif
          end
        end
`ifdef DMEM_WAIT_STATE_EN
        WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            if (r_op == OP_RD) begin
              r_dataOut <= w_memRdata;
            end
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
`endif
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign Data_out = r_dataOut;
  assign ready    = w_idle;
  assign done     = r_done;
  assign err      = r_err;

endmodule
